// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory initialisation front-end:
// FSM state encoding, default memory depth and clear-counter sizing.
package dmem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int DMEM_DEPTH = 2048;
  localparam int DMEM_CNT_W = $clog2(DMEM_DEPTH);

  // A one-word memory still needs a one-bit counter.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_loader.sv
// Owns the data-memory port until the image is valid: zero every word,
// stream (addr, data) beats in, then hand the port to the MEM stage.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              cpu_MemRead,
  input  logic              cpu_MemWrite,
  input  logic [ADDR_W-1:0] cpu_Address,
  input  logic [DATA_W-1:0] cpu_WriteVal,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_WriteVal,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W    = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] clr_cnt;
  logic             in_range;
  logic             beat;

  assign in_range = (ld_addr < DEPTH_A);
  // Ready is high for the whole of LOAD, so any valid beat there is accepted.
  assign beat     = (state == ST_LOAD) && ld_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_CLEAR) && (clr_cnt != CNT_LAST)) begin
        clr_cnt <= clr_cnt + 1'b1;
      end else begin
        clr_cnt <= '0;
      end
      if ((state == ST_RUN) && start) begin
        err <= 1'b0;
      end else if (beat && !in_range) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    mem_Address  = '0;
    mem_WriteVal = '0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    ld_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        mem_MemWrite = 1'b1;
        mem_Address  = ADDR_W'(clr_cnt);
        if (clr_cnt == CNT_LAST) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_ready     = 1'b1;
        mem_Address  = ld_addr;
        mem_WriteVal = ld_data;
        // Out-of-range beats are consumed but never reach the array.
        mem_MemWrite = ld_valid && in_range;
        if (ld_valid && ld_last) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_MemRead  = cpu_MemRead;
        mem_MemWrite = cpu_MemWrite;
        mem_Address  = cpu_Address;
        mem_WriteVal = cpu_WriteVal;
        cpu_hold     = 1'b0;
        done         = 1'b1;
        if (start) begin
          state_nxt = ST_CLEAR;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: a behavioural data memory sits on the
// mem_* port, and a reference image model predicts every CPU read.
module tb_dmem_loader;

  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              cpu_MemRead;
  logic              cpu_MemWrite;
  logic [ADDR_W-1:0] cpu_Address;
  logic [DATA_W-1:0] cpu_WriteVal;
  logic              mem_MemRead;
  logic              mem_MemWrite;
  logic [ADDR_W-1:0] mem_Address;
  logic [DATA_W-1:0] mem_WriteVal;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_err;
  logic [DATA_W-1:0] mem     [DEPTH];

  always #5 clk = ~clk;

  dmem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite),
    .cpu_Address(cpu_Address), .cpu_WriteVal(cpu_WriteVal),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_Address(mem_Address), .mem_WriteVal(mem_WriteVal),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  // Data memory: garbage while reset is held, so zeroing is observable.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom | 32'h1;
    end else if (mem_MemWrite === 1'b1 && mem_Address < 32'(DEPTH)) begin
      mem[mem_Address[AW-1:0]] <= mem_WriteVal;
    end
  end

  function automatic void ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_err = 1'b0;
  endfunction

  function automatic void ref_beat(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'(DEPTH)) ref_mem[a[AW-1:0]] = d;
    else ref_err = 1'b1;
  endfunction

  task automatic drive_idle();
    start = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
    cpu_MemRead = 0; cpu_MemWrite = 0; cpu_Address = '0; cpu_WriteVal = '0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] d, input logic last,
                           output logic wr, output logic [31:0] ma, output logic [31:0] md,
                           output logic rdy);
    ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
    #1;
    wr = mem_MemWrite; ma = mem_Address; md = mem_WriteVal; rdy = ld_ready;
    ref_beat(a, d);
    @(negedge clk);
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] v, output logic rd);
    cpu_MemRead = 1; cpu_Address = a;
    #1;
    rd = mem_MemRead;
    v  = mem[mem_Address[AW-1:0]];
    @(negedge clk);
    cpu_MemRead = 0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    cpu_MemWrite = 1; cpu_Address = a; cpu_WriteVal = d;
    if (a < 32'(DEPTH)) ref_mem[a[AW-1:0]] = d;
    @(negedge clk);
    cpu_MemWrite = 0;
  endtask

  task automatic wait_load(input int budget, output int cycles);
    cycles = 0;
    #1;
    while (ld_ready !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_reinit(output int cycles);
    start = 1;
    @(negedge clk);
    start = 0;
    ref_clear();
    wait_load(DEPTH + 8, cycles);
  endtask

  task automatic test_reset();
    rst = 1; start = 1; ld_valid = 1; cpu_MemRead = 1; cpu_MemWrite = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b want=1", cpu_hold); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ld_ready); end
    total++; if (mem_MemWrite !== 1'b0 || mem_MemRead !== 1'b0) begin
      bad++; $display("FAIL reset_mem got=%b%b want=00", mem_MemWrite, mem_MemRead); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    drive_idle();
    rst = 0;
    ref_clear();
    #1;
    total++; if (mem_MemWrite !== 1'b0 || ld_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++; $display("FAIL idle_cycle got wr=%b rdy=%b hold=%b want 0 0 1", mem_MemWrite, ld_ready, cpu_hold); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    int nbad;
    int first;
    nbad = 0; first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'($urandom); ld_addr = $urandom_range(0, DEPTH - 1); ld_data = $urandom;
      start = 1'($urandom); cpu_MemWrite = 1'($urandom); cpu_Address = $urandom;
      #1;
      if (mem_MemWrite !== 1'b1 || mem_Address !== 32'(i) || mem_WriteVal !== 32'h0 ||
          ld_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_MemRead !== 1'b0) begin
        nbad++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    drive_idle();
    #1;
    total++; if (nbad !== 0) begin
      bad++; $display("FAIL clear_seq got=%0d bad cycles (first at word %0d) want=0", nbad, first); end
    total++; if (ld_ready !== 1'b1 || mem_MemWrite !== 1'b0) begin
      bad++; $display("FAIL ready_cycle got rdy=%b wr=%b want 1 0 on cycle %0d", ld_ready, mem_MemWrite, DEPTH + 2); end
  endtask

  task automatic test_load_image();
    logic [31:0] ba [4];
    logic [31:0] bd [4];
    logic        wr, rdy, rd;
    logic [31:0] ma, md, v;
    ba = '{32'd900, 32'd901, 32'd1000, 32'd1004};
    bd = '{32'd1000, 32'd1004, 32'd5, 32'd1};
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid = 0; ld_addr = $urandom; #1;
        total++; if (mem_MemWrite !== 1'b0 || ld_ready !== 1'b1) begin
          bad++; $display("FAIL load_wait got wr=%b rdy=%b want 0 1", mem_MemWrite, ld_ready); end
        @(negedge clk);
      end
      send_beat(ba[i], bd[i], i == 3, wr, ma, md, rdy);
      total++; if (wr !== 1'b1 || ma !== ba[i] || md !== bd[i] || rdy !== 1'b1) begin
        bad++; $display("FAIL load_beat%0d got wr=%b a=%0d d=%0d want 1 %0d %0d", i, wr, ma, md, ba[i], bd[i]); end
    end
    #1;
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || ld_ready !== 1'b0) begin
      bad++; $display("FAIL load_done got done=%b hold=%b rdy=%b want 1 0 0", done, cpu_hold, ld_ready); end
    ld_valid = 1; ld_addr = 32'd7; ld_data = 32'd55; #1;
    total++; if (mem_MemWrite !== 1'b0) begin
      bad++; $display("FAIL run_ignores_ld got wr=%b want 0", mem_MemWrite); end
    @(negedge clk);
    ld_valid = 0;
    cpu_read(32'd900, v, rd);
    total++; if (v !== 32'd1000 || rd !== 1'b1) begin bad++; $display("FAIL read900 got=%0d rd=%b want 1000", v, rd); end
    cpu_read(32'd1004, v, rd);
    total++; if (v !== 32'd1) begin bad++; $display("FAIL read1004 got=%0d want 1", v); end
    cpu_read(32'd1001, v, rd);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL read1001 got=%0d want 0", v); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, DEPTH - 1);
      cpu_read(a, v, rd);
      total++; if (v !== ref_mem[a[AW-1:0]]) begin
        bad++; $display("FAIL read_rand a=%0d got=%0h want=%0h", a, v, ref_mem[a[AW-1:0]]); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL load_err got=%b want 0", err); end
  endtask

  task automatic test_back_to_back();
    int          c;
    logic        rd;
    logic [31:0] v;
    logic [31:0] a;
    do_reinit(c);
    total++; if (ld_ready !== 1'b1 || c !== DEPTH) begin
      bad++; $display("FAIL reinit_latency got=%0d cycles rdy=%b want %0d", c, ld_ready, DEPTH); end
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1; ld_addr = $urandom_range(0, 31); ld_data = $urandom; ld_last = (i == 7);
      #1;
      total++; if (mem_MemWrite !== 1'b1 || mem_Address !== ld_addr || mem_WriteVal !== ld_data || ld_ready !== 1'b1) begin
        bad++; $display("FAIL stream_beat%0d got wr=%b a=%0d d=%0h want 1 %0d %0h", i, mem_MemWrite, mem_Address, mem_WriteVal, ld_addr, ld_data); end
      ref_beat(ld_addr, ld_data);
      @(negedge clk);
    end
    ld_valid = 0; ld_last = 0;
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stream_done got=%b want 1", done); end
    for (int i = 0; i < 32; i++) begin
      cpu_read(32'(i), v, rd);
      total++; if (v !== ref_mem[i]) begin
        bad++; $display("FAIL stream_read a=%0d got=%0h want=%0h", i, v, ref_mem[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(32, DEPTH - 1);
      cpu_write(a, $urandom);
      cpu_read(a, v, rd);
      total++; if (v !== ref_mem[a[AW-1:0]]) begin
        bad++; $display("FAIL run_rw a=%0d got=%0h want=%0h", a, v, ref_mem[a[AW-1:0]]); end
    end
  endtask

  task automatic test_out_of_range();
    int          c;
    logic        wr, rdy, rd;
    logic [31:0] ma, md, v;
    do_reinit(c);
    send_beat(32'd2048, 32'd7, 1'b0, wr, ma, md, rdy);
    total++; if (wr !== 1'b0 || rdy !== 1'b1) begin
      bad++; $display("FAIL oor_nowrite got wr=%b rdy=%b want 0 1", wr, rdy); end
    #1;
    total++; if (err !== ref_err || err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want 1", err); end
    send_beat(32'd3, 32'd42, 1'b0, wr, ma, md, rdy);
    send_beat(32'h8000_0000 | $urandom, $urandom, 1'b1, wr, ma, md, rdy);
    total++; if (wr !== 1'b0) begin bad++; $display("FAIL oor_last_nowrite got=%b want 0", wr); end
    #1;
    total++; if (done !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL oor_last_ends got done=%b err=%b want 1 1", done, err); end
    cpu_read(32'd3, v, rd);
    total++; if (v !== 32'd42) begin bad++; $display("FAIL oor_read3 got=%0d want 42", v); end
    cpu_read(32'd0, v, rd);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL oor_read0 got=%0d want 0", v); end
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want 1", err); end
    start = 1;
    @(negedge clk);
    start = 0;
    ref_clear();
    #1;
    total++; if (err !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL start_clears got err=%b hold=%b done=%b want 0 1 0", err, cpu_hold, done); end
    wait_load(DEPTH + 8, c);
    send_beat(32'd1, 32'd11, 1'b1, wr, ma, md, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL oor_reload got rdy=%b want 1", rdy); end
  endtask

  task automatic test_reinit();
    int          c;
    logic        wr, rdy, rd;
    logic [31:0] ma, md, v, d0;
    cpu_MemWrite = 1; cpu_Address = 32'd5; cpu_WriteVal = 32'd99;
    #1;
    total++; if (mem_MemWrite !== 1'b1 || mem_Address !== 32'd5 || mem_WriteVal !== 32'd99) begin
      bad++; $display("FAIL run_pass got wr=%b a=%0d d=%0d want 1 5 99", mem_MemWrite, mem_Address, mem_WriteVal); end
    @(negedge clk);
    cpu_MemWrite = 0;
    cpu_read(32'd5, v, rd);
    total++; if (v !== 32'd99) begin bad++; $display("FAIL reinit_read5_pre got=%0d want 99", v); end
    start = 1; cpu_MemWrite = 1; cpu_Address = 32'd6; cpu_WriteVal = 32'd77;
    @(negedge clk);
    start = 0; cpu_MemWrite = 0;
    #1;
    total++; if (mem[6] !== 32'd77) begin bad++; $display("FAIL start_store got=%0d want 77", mem[6]); end
    total++; if (cpu_hold !== 1'b1 || done !== 1'b0 || mem_MemWrite !== 1'b1 || mem_Address !== 32'd0) begin
      bad++; $display("FAIL reinit_clear0 got hold=%b done=%b wr=%b a=%0d want 1 0 1 0", cpu_hold, done, mem_MemWrite, mem_Address); end
    ref_clear();
    wait_load(DEPTH + 8, c);
    d0 = $urandom;
    send_beat(32'd0, d0, 1'b1, wr, ma, md, rdy);
    cpu_read(32'd5, v, rd);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reinit_read5 got=%0d want 0", v); end
    cpu_read(32'd6, v, rd);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reinit_read6 got=%0d want 0", v); end
    cpu_read(32'd0, v, rd);
    total++; if (v !== d0) begin bad++; $display("FAIL reinit_read0 got=%0h want=%0h", v, d0); end
  endtask

  task automatic test_reset_mid_load();
    int          c;
    logic        wr, rdy, rd;
    logic [31:0] ma, md, v, d;
    do_reinit(c);
    send_beat(32'd10, $urandom | 32'h1, 1'b0, wr, ma, md, rdy);
    send_beat(32'd2053, $urandom, 1'b0, wr, ma, md, rdy);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL midload_err_pre got=%b want 1", err); end
    rst = 1;
    #1;
    total++; if (err !== 1'b0 || cpu_hold !== 1'b1 || ld_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midload_rst got err=%b hold=%b rdy=%b done=%b want 0 1 0 0", err, cpu_hold, ld_ready, done); end
    @(negedge clk);
    rst = 0;
    ref_clear();
    wait_load(DEPTH + 8, c);
    total++; if (c !== DEPTH + 1 || err !== 1'b0) begin
      bad++; $display("FAIL midload_replay got=%0d cycles err=%b want %0d 0", c, err, DEPTH + 1); end
    d = $urandom;
    send_beat(32'd20, d, 1'b1, wr, ma, md, rdy);
    cpu_read(32'd10, v, rd);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL midload_read10 got=%0h want 0", v); end
    cpu_read(32'd20, v, rd);
    total++; if (v !== d) begin bad++; $display("FAIL midload_read20 got=%0h want=%0h", v, d); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    rst = 1;
    test_reset();
    test_clear();
    test_load_image();
    test_back_to_back();
    test_out_of_range();
    test_reinit();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Initialisation front-end that sits directly upstream of the data memory and owns its single access port until the memory image is valid. After reset it zeroes every word, then accepts an (address, data) stream over a valid/ready handshake and writes it in. Once the last beat arrives it hands the port to the pipeline's MEM stage and releases the processor. Hard-coded test images are replaced by streamed loads.

## Interface
Parameters:
- DEPTH, 2048: number of 32-bit words in the data memory.
- ADDR_W, 32: address width on all address ports.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  re-initialise request; honoured only in RUN.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat ready.
- ld_addr  in  ADDR_W  word address of the beat.
- ld_data  in  DATA_W  word value of the beat.
- ld_last  in  1  marks the final beat of the image.
- cpu_MemRead  in  1  MEM-stage read request.
- cpu_MemWrite  in  1  MEM-stage write request.
- cpu_Address  in  ADDR_W  MEM-stage word address.
- cpu_WriteVal  in  DATA_W  MEM-stage store data.
- mem_MemRead  out  1  to data memory.
- mem_MemWrite  out  1  to data memory.
- mem_Address  out  ADDR_W  to data memory.
- mem_WriteVal  out  DATA_W  to data memory.
- cpu_hold  out  1  stalls the whole pipeline while high.
- done  out  1  image valid; the CPU owns the port.
- err  out  1  sticky; set when a beat had ld_addr >= DEPTH.

## Operation
- States: IDLE, CLEAR, LOAD, RUN. Reset state is IDLE.
- **IDLE**
  - All mem_* outputs are 0, cpu_hold=1, done=0, ld_ready=0.
  - Always moves to CLEAR on the next edge.
- **CLEAR**
  - mem_MemWrite=1, mem_Address=clr_cnt (zero-extended), mem_WriteVal=0.
  - clr_cnt counts 0..DEPTH-1, one word per cycle.
  - At clr_cnt==DEPTH-1: move to LOAD and reset clr_cnt to 0.
- **LOAD**
  - ld_ready=1. mem_Address=ld_addr, mem_WriteVal=ld_data.
  - mem_MemWrite = ld_valid & (ld_addr < DEPTH).
  - A beat is accepted when ld_valid & ld_ready at an edge; the write lands on that same edge.
  - An out-of-range beat is accepted but not written, and sets err.
  - An accepted beat with ld_last=1 moves the block to RUN.
  - With no beats, the block waits in LOAD indefinitely.
- **RUN**
  - mem_* = cpu_* (combinational pass-through). cpu_hold=0, done=1, ld_ready=0.
  - start=1 at an edge moves the block to CLEAR. From that cycle: cpu_hold=1, done=0, err cleared.
- Handshake and request rules:
  - ld_valid outside LOAD is ignored.
  - start outside RUN is ignored.
  - cpu_* requests while cpu_hold=1 are ignored; the pipeline is stalled.
- mem_MemRead is 0 in every state except RUN.

## Timing
- Reset values (asynchronous, while rst is high):
  - state=IDLE, clr_cnt=0, err=0.
  - cpu_hold=1, done=0, ld_ready=0, mem_MemWrite=0, mem_MemRead=0.
- Reset mid-CLEAR or mid-LOAD abandons the operation. The full sequence restarts from IDLE and partial contents are re-zeroed.
- Initialisation latency: 1 cycle (IDLE) + DEPTH cycles (CLEAR) + N accepted beats. done rises the cycle after the ld_last beat's edge.
- Zero-wait load: a new beat is accepted every cycle ld_valid is high in LOAD.
- A beat with ld_last=1 and out-of-range address still ends the load and sets err.
- Duplicate addresses in LOAD: the later beat wins.
- start and a cpu_MemWrite in the same RUN cycle: the store still reaches memory on that edge; CLEAR begins the next cycle.

## Structure
- A shared package/header holds:
  - the state encoding constants (IDLE=0, CLEAR=1, LOAD=2, RUN=3);
  - the default DEPTH (2048) and the derived counter width clog2(DEPTH).
- No sub-module: one FSM, one clear counter, one sticky flag and the output mux.
- The top level instantiates dmem_loader between the MEM stage and the data memory. cpu_hold ORs into the global stall.

## Test plan
- **Reset then clear (DEPTH=16):** rst pulse, then idle inputs → mem_MemWrite=1 for exactly 16 cycles with addresses 0..15 and data 0; ld_ready rises on cycle 18.
- **Load image:** beats (900,1000), (901,1004), (1000,5), (1004,1 with ld_last) → done=1 the next cycle; CPU reads of 900 and 1004 return 1000 and 1; a read of 1001 returns 0.
- **Backpressure-free streaming:** ld_valid held high for 8 consecutive beats → 8 writes on 8 consecutive edges, none dropped.
- **Out-of-range beat:** ld_addr=2048 with data 7 → no mem write; err=1 and stays 1 through RUN; start clears it.
- **Re-init:** in RUN, write 99 to address 5, then assert start → cpu_hold=1 next cycle; after CLEAR and a single ld_last beat to address 0, a read of 5 returns 0.
- **Reset mid-LOAD:** rst after 2 of 4 beats → IDLE, err=0, full clear replays, and previously loaded words read 0.
